// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads to a one-cycle
// synchronous instruction memory and buffers responses in a small FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          flush;
    logic          push;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        instr_valid = !reset && (count != '0);
        pop         = instr_valid && instr_ready;
        flush       = pop && redirect;
        push        = inflight && !flush && !reset;
        // Slots already promised (queued + in flight) after this cycle's pop;
        // a new request is allowed only while one slot remains unclaimed.
        occupancy   = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
        imem_req    = !reset && (flush || (occupancy < (CW + 1)'(DEPTH)));
        if (reset)
            imem_addr = RESET_PC;
        else if (flush)
            imem_addr = {redirect_target[31:2], 2'b00};
        else
            imem_addr = fetch_pc;
        instr    = q_instr[rd_ptr];
        instr_pc = q_pc[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + 32'd4;
            end
            if (push) begin
                q_instr[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr]    <= inflight_pc;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // A redirect is only meaningful for an instruction accepted this cycle.
    redirect_needs_pop: assert property (@(posedge clk) disable iff (reset) redirect |-> pop);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus a scoreboard of expected
// delivered PCs, with two instances (RESET_PC 0 / DEPTH 2, RESET_PC wrap / DEPTH 3).
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0, ready0, redirect0, req0, valid0;
    logic [31:0] target0, addr0, rdata0, instr0, pc0;
    logic        reset1, ready1, redirect1, req1, valid1;
    logic [31:0] target1, addr1, rdata1, instr1, pc1;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk(clk), .reset(reset0), .imem_req(req0), .imem_addr(addr0),
        .imem_rdata(rdata0), .instr_valid(valid0), .instr(instr0),
        .instr_pc(pc0), .instr_ready(ready0), .redirect(redirect0),
        .redirect_target(target0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) dut1 (
        .clk(clk), .reset(reset1), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .instr_valid(valid1), .instr(instr1),
        .instr_pc(pc1), .instr_ready(ready1), .redirect(redirect1),
        .redirect_target(target1)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0000_0013 + ((a >> 2) << 7);
    endfunction

    always @(posedge clk) begin
        rdata0 <= word(addr0);
        rdata1 <= word(addr1);
    end

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        stall_tbl [14];
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int          n_checks;
    int          n_fail;
    int          reqs0;
    logic [31:0] w_addr [11];
    logic        w_req  [11];
    logic        c_valid [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
    endtask

    task automatic end_cycle();
        logic [31:0] e;
        #1;
        if (req0) reqs0++;
        if (valid0 && ready0) begin
            if (sb0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb0_unexpected: got pc %h, required no delivery", pc0);
            end else begin
                e = sb0.pop_front();
                check("sb0_pc", pc0, e);
                check("sb0_instr", instr0, word(e));
            end
        end
        if (valid1 && ready1) begin
            if (sb1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb1_unexpected: got pc %h, required no delivery", pc1);
            end else begin
                e = sb1.pop_front();
                check("sb1_pc", pc1, e);
                check("sb1_instr", instr1, word(e));
            end
        end
    endtask

    task automatic reset_dut0();
        begin_cycle();
        reset0 = 1'b1; ready0 = 1'b0; redirect0 = 1'b0;
        end_cycle();
        sb0.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset0 = 1'b1; ready0 = 1'b0; redirect0 = 1'b0; target0 = '0;
        reset1 = 1'b1; ready1 = 1'b0; redirect1 = 1'b0; target1 = '0;
        n_checks = 0; n_fail = 0; reqs0 = 0;

        stall_tbl[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        stall_tbl[1] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
        for (int i = 2; i <= 9; i++) stall_tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        stall_tbl[10] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
        stall_tbl[11] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
        stall_tbl[12] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        stall_tbl[13] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

        w_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0,
                   32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        w_req  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        c_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset values on both instances
        begin_cycle(); end_cycle();
        begin_cycle(); end_cycle();
        check("rst_req0", 32'(req0), 32'd0);
        check("rst_valid0", 32'(valid0), 32'd0);
        check("rst_instr0", instr0, 32'h0);
        check("rst_pc0", pc0, 32'h0);
        check("rst_addr0", addr0, 32'h0);
        check("rst_req1", 32'(req1), 32'd0);
        check("rst_addr1", addr1, 32'hFFFF_FFF8);

        // Steady stream, then one-cycle reset with a request in flight
        for (int i = 0; i < 6; i++) sb0.push_back(32'(i * 4));
        for (int c = 0; c < 8; c++) begin
            begin_cycle(); reset0 = 1'b0; ready0 = 1'b1; end_cycle();
            check("a_req", 32'(req0), 32'd1);
            check("a_addr", addr0, 32'(c * 4));
            check("a_valid", 32'(valid0), 32'(c >= 2));
        end
        check("a_drain", 32'(sb0.size()), 32'd0);
        begin_cycle(); reset0 = 1'b1; end_cycle();
        check("rstmid_valid", 32'(valid0), 32'd0);
        check("rstmid_req", 32'(req0), 32'd0);
        sb0.delete();
        sb0.push_back(32'h0); sb0.push_back(32'h4);
        for (int c = 0; c < 4; c++) begin
            begin_cycle(); reset0 = 1'b0; ready0 = 1'b1; end_cycle();
            check("rstmid_after_valid", 32'(valid0), 32'(c >= 2));
            check("rstmid_after_addr", addr0, 32'(c * 4));
        end
        check("rstmid_drain", 32'(sb0.size()), 32'd0);

        // Reset with two entries queued
        reset_dut0();
        for (int c = 0; c < 4; c++) begin
            begin_cycle(); reset0 = 1'b0; ready0 = 1'b0; end_cycle();
        end
        check("full_valid", 32'(valid0), 32'd1);
        check("full_pc", pc0, 32'h0);
        check("full_req", 32'(req0), 32'd0);
        begin_cycle(); reset0 = 1'b1; end_cycle();
        check("rstfull_valid", 32'(valid0), 32'd0);
        sb0.delete();
        sb0.push_back(32'h0); sb0.push_back(32'h4);
        for (int c = 0; c < 4; c++) begin
            begin_cycle(); reset0 = 1'b0; ready0 = 1'b1; end_cycle();
            if (c == 0) begin
                check("rstfull_instr", instr0, 32'h0);
                check("rstfull_addr", addr0, 32'h0);
            end
            check("rstfull_after_valid", 32'(valid0), 32'(c >= 2));
        end
        check("rstfull_drain", 32'(sb0.size()), 32'd0);

        // Stall table
        reset_dut0();
        reqs0 = 0;
        for (int i = 0; i < 4; i++) sb0.push_back(32'(i * 4));
        for (int c = 0; c < 14; c++) begin
            begin_cycle(); reset0 = 1'b0; ready0 = stall_tbl[c].ready; end_cycle();
            check("stall_req", 32'(req0), 32'(stall_tbl[c].exp_req));
            if (stall_tbl[c].exp_req) check("stall_addr", addr0, stall_tbl[c].exp_addr);
            check("stall_valid", 32'(valid0), 32'(stall_tbl[c].exp_valid));
            if (stall_tbl[c].exp_valid) begin
                check("stall_pc", pc0, stall_tbl[c].exp_pc);
                check("stall_instr", instr0, word(stall_tbl[c].exp_pc));
            end
            if (c == 10) check("stall_reqs", 32'(reqs0), 32'd3);
        end
        check("stall_drain", 32'(sb0.size()), 32'd0);

        // Redirects: aligned target, then misaligned target
        reset_dut0();
        sb0 = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h200, 32'h204};
        for (int c = 0; c < 11; c++) begin
            begin_cycle();
            reset0 = 1'b0; ready0 = 1'b1;
            redirect0 = (c == 4) || (c == 7);
            target0 = (c == 4) ? 32'h0000_0100 : 32'h0000_0203;
            end_cycle();
            check("redir_valid", 32'(valid0), 32'(c_valid[c]));
            if (c == 4) check("redir_addr", addr0, 32'h100);
            if (c == 5) check("redir_next_addr", addr0, 32'h104);
            if (c == 7) check("redir_mis_addr", addr0, 32'h200);
            if (c == 4 || c == 7) check("redir_req", 32'(req0), 32'd1);
        end
        begin_cycle(); reset0 = 1'b1; redirect0 = 1'b0; ready0 = 1'b0; end_cycle();
        check("redir_drain", 32'(sb0.size()), 32'd0);

        // PC wrap on the DEPTH=3 instance, including a fill to DEPTH
        sb1 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        for (int c = 0; c < 11; c++) begin
            begin_cycle(); reset1 = 1'b0; ready1 = (c >= 6); end_cycle();
            check("wrap_req", 32'(req1), 32'(w_req[c]));
            if (w_req[c]) check("wrap_addr", addr1, w_addr[c]);
            check("wrap_valid", 32'(valid1), 32'(c >= 2));
            if (c >= 2 && c <= 5) check("wrap_hold_pc", pc1, 32'hFFFF_FFF8);
        end
        check("wrap_drain", 32'(sb1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
